// File: rtl/reg32_write_distributor.sv
// Write-side distributor for a bank of 2**ADDR_W registers.
// Handles single writes, auto-incrementing burst writes with wrap-around,
// and a one-entry-per-cycle clear sweep.
// The bank is exposed as a flat bus for the downstream 32-to-1 read mux.
module reg32_write_distributor #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [WIDTH-1:0]                wr_data,
    input  logic                            burst_start,
    input  logic [ADDR_W-1:0]               burst_addr,
    input  logic [ADDR_W:0]                 burst_len,
    input  logic                            clr,
    output logic [WIDTH*(2**ADDR_W)-1:0]    q_flat,
    output logic [(2**ADDR_W)-1:0]          wr_flag,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StIdle, StBurst, StClear} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   bank_q [DEPTH];
    logic [DEPTH-1:0]   flag_q;

    logic               we;
    logic [ADDR_W-1:0]  waddr;
    logic [WIDTH-1:0]   wdata;
    logic               wflag;
    logic               len_ok;

    // Legal lengths are 1..DEPTH: nonzero, and if the top bit is set the rest must be zero.
    assign len_ok = (burst_len != '0) &&
                    (!burst_len[ADDR_W] || (burst_len[ADDR_W-1:0] == '0));

    // Next-state, write-port and handshake decode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        we       = 1'b0;
        waddr    = ptr_q;
        wdata    = wr_data;
        wflag    = 1'b1;
        wr_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                // clr and burst_start both suppress any coincident single write.
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end else if (burst_start) begin
                    if (len_ok) begin
                        state_d = StBurst;
                        ptr_d   = burst_addr;
                        cnt_d   = burst_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    wr_ready = 1'b1;
                    if (wr_valid) begin
                        we    = 1'b1;
                        waddr = wr_addr;
                    end
                end
            end
            StBurst: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StClear: begin
                we    = 1'b1;
                wdata = '0;
                wflag = 1'b0;
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (reset) begin
            wr_ready = 1'b0;
        end
    end

    // Control state, pulses and bank storage with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (we) begin
                bank_q[waddr] <= wdata;
                flag_q[waddr] <= wflag;
            end
        end
    end

    // Entry k occupies q_flat[WIDTH*k +: WIDTH].
    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign q_flat[k*WIDTH +: WIDTH] = bank_q[k];
    end

    assign wr_flag = flag_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_reg32_write_distributor.sv
// Self-checking bench for reg32_write_distributor.
// Expected writes go into a scoreboard queue as they are driven.
// Each one is popped and compared after the DUT's write edge.
module tb_reg32_write_distributor;

    logic          clk = 1'b0;
    logic          reset, wr_valid, burst_start, clr;
    logic          wr_ready;
    logic [4:0]    wr_addr, burst_addr;
    logic [31:0]   wr_data;
    logic [5:0]    burst_len;
    logic [1023:0] q_flat;
    logic [31:0]   wr_flag;
    logic          busy, done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb [$];
    logic [31:0] mbank [32];
    logic [31:0] mflag;

    always #5 clk = ~clk;

    reg32_write_distributor dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .burst_start (burst_start),
        .burst_addr  (burst_addr),
        .burst_len   (burst_len),
        .clr         (clr),
        .q_flat      (q_flat),
        .wr_flag     (wr_flag),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int k = 0; k < 32; k++) mbank[k] = '0;
        mflag = '0;
        sb.delete();
    endtask

    function automatic logic [1023:0] model_flat();
        logic [1023:0] r;
        for (int k = 0; k < 32; k++) r[k*32 +: 32] = mbank[k];
        return r;
    endfunction

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
        mbank[a] = d;
        mflag[a] = 1'b1;
    endtask

    task automatic test_reset;
        model_clear();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", wr_ready);
        end
        checks++;
        if (q_flat !== '0 || wr_flag !== '0) begin
            errors++; $display("FAIL reset_bank got flag %h exp 0", wr_flag);
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++; $display("FAIL reset_status got %b exp 000", {busy, done, err});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready_after got %b exp 1", wr_ready);
        end
    endtask

    task automatic test_single;
        wr_t e;
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_0078;
        push(5'd5, 32'h78);
        step();
        wr_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (q_flat[191:160] !== e.data) begin
            errors++; $display("FAIL single_data got %h exp %h", q_flat[191:160], e.data);
        end
        checks++;
        if (wr_flag !== 32'h0000_0020) begin
            errors++; $display("FAIL single_flag got %h exp 00000020", wr_flag);
        end
        checks++;
        if (q_flat !== model_flat()) begin
            errors++; $display("FAIL single_others got %h", q_flat);
        end
    endtask

    task automatic test_burst;
        wr_t e;
        logic [31:0] dat [4] = '{32'd1, 32'd2, 32'd3, 32'd4};
        burst_start = 1'b1; burst_addr = 5'd30; burst_len = 6'd4;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL burst_start_ready got %b exp 0", wr_ready);
        end
        step();
        burst_start = 1'b0; wr_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || mbank[9] !== q_flat[9*32 +: 32]) begin
            errors++; $display("FAIL burst_enter busy %b entry9 %h exp busy 1 entry9 %h",
                               busy, q_flat[9*32 +: 32], mbank[9]);
        end
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = dat[i];
            push(5'(30 + i), dat[i]);
            step();
            wr_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (q_flat[e.addr*32 +: 32] !== e.data || wr_flag[e.addr] !== 1'b1) begin
                errors++; $display("FAIL burst_beat%0d got %h flag %b exp %h flag 1",
                                   i, q_flat[e.addr*32 +: 32], wr_flag[e.addr], e.data);
            end
            if (i < 3) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++; $display("FAIL burst_midway%0d busy %b done %b exp 1 0", i, busy, done);
                end
            end
            if (i == 1) begin
                step();
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || q_flat !== model_flat()) begin
                    errors++; $display("FAIL burst_stall busy %b done %b exp 1 0", busy, done);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL burst_done done %b busy %b exp 1 0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || q_flat !== model_flat() || wr_flag !== mflag) begin
            errors++; $display("FAIL burst_final done %b flag %h exp 0 flag %h", done, wr_flag, mflag);
        end
    endtask

    task automatic test_err;
        logic [5:0] lens [2] = '{6'd0, 6'd33};
        for (int i = 0; i < 2; i++) begin
            burst_start = 1'b1; burst_len = lens[i]; burst_addr = 5'd2;
            step();
            burst_start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL err_len%0d err %b busy %b exp 1 0", lens[i], err, busy);
            end
            step();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || q_flat !== model_flat()) begin
                errors++; $display("FAIL err_after%0d err %b busy %b exp 0 0", lens[i], err, busy);
            end
        end
    endtask

    task automatic test_clear;
        wr_t e;
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_addr = 5'(i); wr_data = $urandom | 32'h1;
            push(5'(i), wr_data);
            step();
            e = sb.pop_front();
            checks++;
            if (q_flat[e.addr*32 +: 32] !== e.data) begin
                errors++; $display("FAIL fill%0d got %h exp %h", i, q_flat[e.addr*32 +: 32], e.data);
            end
        end
        checks++;
        if (wr_flag !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL fill_flag got %h exp ffffffff", wr_flag);
        end
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL clr_ready got %b exp 0", wr_ready);
        end
        step();
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_addr = 5'($urandom_range(0, 31)); wr_data = $urandom;
            checks++;
            if (wr_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL clr_cycle%0d ready %b busy %b done %b exp 0 1 0",
                                   i, wr_ready, busy, done);
            end
            step();
        end
        wr_valid = 1'b0;
        model_clear();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++; $display("FAIL clr_done done %b busy %b ready %b exp 1 0 1", done, busy, wr_ready);
        end
        checks++;
        if (q_flat !== '0 || wr_flag !== '0) begin
            errors++; $display("FAIL clr_bank flag %h exp 0", wr_flag);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL clr_done_once got %b exp 0", done);
        end
    endtask

    task automatic test_simultaneous;
        wr_t e;
        int  waited;
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        push(5'd3, 32'h11);
        step();
        e = sb.pop_front();
        checks++;
        if (q_flat[e.addr*32 +: 32] !== e.data) begin
            errors++; $display("FAIL simul_pre got %h exp %h", q_flat[e.addr*32 +: 32], e.data);
        end
        clr = 1'b1; burst_start = 1'b1; burst_addr = 5'd7; burst_len = 6'd2;
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hFF;
        step();
        clr = 1'b0; burst_start = 1'b0; wr_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || q_flat[3*32 +: 32] !== 32'h11) begin
            errors++; $display("FAIL simul_enter busy %b ready %b entry3 %h exp 1 0 00000011",
                               busy, wr_ready, q_flat[3*32 +: 32]);
        end
        waited = 0;
        while (done !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        model_clear();
        checks++;
        if (done !== 1'b1 || waited != 32 || q_flat !== '0 || wr_flag !== '0) begin
            errors++; $display("FAIL simul_clear done %b cycles %0d flag %h exp 1 32 0",
                               done, waited, wr_flag);
        end
        step();
    endtask

    task automatic test_back_to_back;
        wr_t e;
        burst_start = 1'b1; burst_addr = 5'd17; burst_len = 6'd32;
        step();
        burst_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1; wr_data = $urandom;
            push(5'(17 + i), wr_data);
            step();
            e = sb.pop_front();
            checks++;
            if (q_flat[e.addr*32 +: 32] !== e.data) begin
                errors++; $display("FAIL b2b_beat%0d got %h exp %h", i, q_flat[e.addr*32 +: 32], e.data);
            end
        end
        wr_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || wr_flag !== 32'hFFFF_FFFF || q_flat !== model_flat()) begin
            errors++; $display("FAIL b2b_end done %b busy %b flag %h exp 1 0 ffffffff", done, busy, wr_flag);
        end
        step();
    endtask

    task automatic test_reset_mid_burst;
        wr_t e;
        burst_start = 1'b1; burst_addr = 5'd10; burst_len = 6'd8;
        step();
        burst_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_valid = 1'b1; wr_data = 32'h100 + i;
            push(5'(10 + i), wr_data);
            step();
            e = sb.pop_front();
            checks++;
            if (q_flat[e.addr*32 +: 32] !== e.data) begin
                errors++; $display("FAIL rstb_beat%0d got %h exp %h", i, q_flat[e.addr*32 +: 32], e.data);
            end
        end
        reset = 1'b1;
        step();
        model_clear();
        checks++;
        if (q_flat !== '0 || wr_flag !== '0 || {busy, done, err, wr_ready} !== 4'b0000) begin
            errors++; $display("FAIL rstb_reset flag %h status %b exp 0 0000",
                               wr_flag, {busy, done, err, wr_ready});
        end
        reset = 1'b0; wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hCAFE;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL rstb_ready got %b exp 1", wr_ready);
        end
        push(5'd0, 32'hCAFE);
        step();
        wr_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (q_flat[31:0] !== e.data || wr_flag !== 32'h1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstb_single got %h flag %h done %b exp %h flag 1 done 0",
                               q_flat[31:0], wr_flag, done, e.data);
        end
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; burst_start = 1'b0; clr = 1'b0;
        wr_addr = '0; wr_data = '0; burst_addr = '0; burst_len = '0;
        test_reset();
        test_single();
        test_burst();
        test_err();
        test_clear();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
